// File: rtl/line_capture_pkg.sv
// linecap_pkg: shared state type and width helpers for the line capture stage
package linecap_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE} lc_state_t;
  function automatic int slot_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int line_max(input int col_w);
    return 1 << col_w;
  endfunction
endpackage

// File: rtl/line_capture_edge.sv
// sync_edge_tracker: per-beat hsync/vsync history and rising-edge strobes
module sync_edge_tracker (
  input  logic clk,
  input  logic rst,
  input  logic beat_i,
  input  logic hsync_i,
  input  logic vsync_i,
  output logic hs_rise_o,
  output logic vs_rise_o,
  output logic hsync_o,
  output logic vsync_o
);
  logic hs_q, vs_q;
  // remember the syncs of the most recent accepted beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (beat_i) begin
      hs_q <= hsync_i;
      vs_q <= vsync_i;
    end
  end
  assign hs_rise_o = beat_i && hsync_i && !hs_q;
  assign vs_rise_o = beat_i && vsync_i && !vs_q;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
endmodule

// File: rtl/line_capture.sv
// line_capture: windows each camera line into a ring of line-memory slots
module line_capture
  import linecap_pkg::*;
#(
  parameter int PIX_W = 12,
  parameter int DATA_W = 16,
  parameter int COL_W = 9,
  parameter int NUM_LINES = 2,
  localparam int SLOT_W = slot_w(NUM_LINES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        src_pixel,
  input  logic                    src_hsync,
  input  logic                    src_vsync,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [COL_W-1:0]        cfg_h_start,
  input  logic [COL_W:0]          cfg_h_len,
  output logic [SLOT_W+COL_W-1:0] lb_addr,
  output logic [DATA_W-1:0]       lb_data,
  output logic                    lb_write,
  input  logic                    lb_ack,
  input  logic                    sr_clear,
  output logic                    sr_hsync,
  output logic                    sr_vsync,
  output logic [SLOT_W-1:0]       sr_slot,
  output logic [SLOT_W-1:0]       sr_last_slot,
  output logic                    sr_line_done,
  output logic [15:0]             sr_frame_ctr,
  output logic                    sr_short_line
);
  localparam logic [COL_W:0] LEN_MAX = (COL_W+1)'(line_max(COL_W));
  lc_state_t state_q, state_d, es;
  logic [COL_W-1:0] col_q, col_d, start_q, start_d, c, off;
  logic [COL_W:0] len_q, len_d;
  logic [SLOT_W-1:0] slot_q, slot_d, last_slot_q, last_slot_d;
  logic [15:0] frame_q, frame_d;
  logic done_q, done_d, short_q, short_d, wr_q, wr_d, fin_q, fin_d;
  logic [SLOT_W+COL_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic beat, line_end, hs_rise, vs_rise, hit;
  assign src_ready = rst && (!wr_q || lb_ack);
  assign beat = src_valid && src_ready;
  assign line_end = wr_q && lb_ack && fin_q;
  sync_edge_tracker u_edge (
    .clk(clk), .rst(rst), .beat_i(beat), .hsync_i(src_hsync), .vsync_i(src_vsync),
    .hs_rise_o(hs_rise), .vs_rise_o(vs_rise), .hsync_o(sr_hsync), .vsync_o(sr_vsync)
  );
  // line completion first, then frame/line starts, then the capture decision for this beat
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    start_d = start_q;
    len_d = len_q;
    slot_d = slot_q;
    last_slot_d = last_slot_q;
    done_d = 1'b0;
    frame_d = frame_q;
    short_d = sr_clear ? 1'b0 : short_q;
    wr_d = wr_q && !lb_ack;
    addr_d = addr_q;
    data_d = data_q;
    fin_d = fin_q;
    es = state_q;
    c = '0;
    off = '0;
    hit = 1'b0;
    if (line_end) begin
      last_slot_d = slot_q;
      slot_d = slot_q + 1'b1;
      done_d = 1'b1;
      es = IDLE;
    end
    if (beat) begin
      c = hs_rise ? '0 : col_q + 1'b1;
      col_d = c;
      if (vs_rise) begin
        slot_d = '0;
        frame_d = frame_q + 16'd1;
        if (es != IDLE) short_d = 1'b1;
        es = IDLE;
      end
      if (hs_rise) begin
        if (es != IDLE) short_d = 1'b1;
        start_d = cfg_h_start;
        len_d = (cfg_h_len > LEN_MAX) ? LEN_MAX : cfg_h_len;
        es = (len_d == '0) ? IDLE : SKIP;
      end
      hit = (es == SKIP && c == start_d) || es == CAPTURE;
      off = c - start_d;
      if (hit) begin
        wr_d = 1'b1;
        addr_d = {slot_d, off};
        data_d = DATA_W'(src_pixel);
        fin_d = ({1'b0, off} == len_d - 1'b1) || (&c);
        es = CAPTURE;
      end
    end
    state_d = es;
  end
  // state and status registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q <= '0;
      start_q <= '0;
      len_q <= '0;
      slot_q <= '0;
      last_slot_q <= '0;
      done_q <= 1'b0;
      frame_q <= '0;
      short_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      start_q <= start_d;
      len_q <= len_d;
      slot_q <= slot_d;
      last_slot_q <= last_slot_d;
      done_q <= done_d;
      frame_q <= frame_d;
      short_q <= short_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      fin_q <= fin_d;
    end
  end
  assign lb_write = wr_q;
  assign lb_addr = addr_q;
  assign lb_data = data_q;
  assign sr_slot = slot_q;
  assign sr_last_slot = last_slot_q;
  assign sr_line_done = done_q;
  assign sr_frame_ctr = frame_q;
  assign sr_short_line = short_q;
endmodule

// File: tb/tb_line_capture.sv
// tb_line_capture: randomized line/frame stimulus against a per-line reference model
module tb_line_capture;
  logic clk = 0, rst = 0;
  logic [11:0] src_pixel = 0;
  logic src_hsync = 0, src_vsync = 0, src_valid = 0, src_ready;
  logic [8:0] cfg_h_start = 0;
  logic [9:0] cfg_h_len = 0;
  logic [10:0] lb_addr;
  logic [15:0] lb_data;
  logic lb_write, lb_ack = 1, sr_clear = 0;
  logic sr_hsync, sr_vsync, sr_line_done, sr_short_line;
  logic [1:0] sr_slot, sr_last_slot;
  logic [15:0] sr_frame_ctr;
  int n_tests = 0, n_fail = 0, done_cnt = 0;
  int ack_mode = 0;
  bit gaps = 0;
  int pix [512];
  int m_slot = 0, m_last = 0, m_frame = 0, m_done = 0;
  bit m_short = 0, m_busy = 0;
  logic [26:0] exp_q [$];
  bit stall = 0;
  logic [26:0] stall_v;

  line_capture #(.PIX_W(12), .DATA_W(16), .COL_W(9), .NUM_LINES(4)) dut (
    .clk(clk), .rst(rst), .src_pixel(src_pixel), .src_hsync(src_hsync), .src_vsync(src_vsync),
    .src_valid(src_valid), .src_ready(src_ready), .cfg_h_start(cfg_h_start), .cfg_h_len(cfg_h_len),
    .lb_addr(lb_addr), .lb_data(lb_data), .lb_write(lb_write), .lb_ack(lb_ack), .sr_clear(sr_clear),
    .sr_hsync(sr_hsync), .sr_vsync(sr_vsync), .sr_slot(sr_slot), .sr_last_slot(sr_last_slot),
    .sr_line_done(sr_line_done), .sr_frame_ctr(sr_frame_ctr), .sr_short_line(sr_short_line)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial forever begin
    @(posedge clk);
    #1;
    lb_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) stall = 0;
    else begin
      if (stall) check("hold", {lb_write, lb_addr, lb_data}, {1'b1, stall_v});
      check("ready", src_ready, !lb_write || lb_ack);
      if (lb_write && lb_ack) begin
        check("write_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("write", {lb_addr, lb_data}, exp_q.pop_front());
      end
      if (sr_line_done) done_cnt++;
      stall = lb_write && !lb_ack;
      stall_v = {lb_addr, lb_data};
    end
  end

  task automatic model_line(input int npix, input int st, input int ln, input bit vs, input bit clr);
    int lnx, endc;
    if (clr) m_short = 0;
    if (vs) begin
      if (m_busy) m_short = 1;
      m_busy = 0;
      m_slot = 0;
      m_frame = (m_frame + 1) % 65536;
    end
    if (m_busy) m_short = 1;
    lnx = (ln > 512) ? 512 : ln;
    endc = (st + lnx > 512) ? 512 : st + lnx;
    for (int c = st; c < endc && c < npix; c++)
      exp_q.push_back({2'(m_slot), 9'(c - st), 16'(pix[c])});
    m_busy = lnx > 0;
    if (m_busy && npix >= endc) begin
      m_last = m_slot;
      m_slot = (m_slot + 1) % 4;
      m_done++;
      m_busy = 0;
    end
  endtask

  task automatic send_beat(input logic [11:0] p, input logic hs, input logic vs, input logic clr);
    int n = 0;
    bit acc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      src_valid = 0;
      @(posedge clk);
      #1;
    end
    src_valid = 1;
    src_pixel = p;
    src_hsync = hs;
    src_vsync = vs;
    sr_clear = clr;
    forever begin
      @(negedge clk);
      acc = src_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 100) begin
        check("beat_wait", acc, 1);
        break;
      end
    end
    sr_clear = 0;
    src_valid = 0;
  endtask

  task automatic send_line(input int npix, input int st, input int ln, input bit vs, input bit clr, input bit seq);
    for (int i = 0; i < 512; i++) pix[i] = seq ? i : int'($urandom_range(0, 4095));
    cfg_h_start = 9'(st);
    cfg_h_len = 10'(ln);
    model_line(npix, st, ln, vs, clr);
    for (int c = 0; c < npix; c++) begin
      send_beat(12'(pix[c]), c == 0, vs && c == 0, clr && c == 0);
      if (c == 0) begin
        cfg_h_start = 9'($urandom);
        cfg_h_len = 10'($urandom);
      end
    end
  endtask

  task automatic line_check(input string tag);
    int n = 0;
    src_valid = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lb_write && n < 400);
    check({tag, "_drain"}, lb_write, 0);
    @(negedge clk);
    check({tag, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_slot"}, sr_slot, m_slot);
    check({tag, "_last"}, sr_last_slot, m_last);
    check({tag, "_frame"}, sr_frame_ctr, m_frame);
    check({tag, "_short"}, sr_short_line, m_short);
    check({tag, "_done"}, done_cnt, m_done);
    check({tag, "_sync"}, {sr_hsync, sr_vsync}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {lb_write, lb_addr, lb_data, sr_hsync, sr_vsync, sr_slot, sr_last_slot,
                sr_line_done, sr_frame_ctr, sr_short_line, src_ready}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset_out");
    @(posedge clk);
    #1;
    rst = 1;
    send_line(10, 2, 5, 0, 0, 1);
    line_check("basic");
    ack_mode = 1;
    gaps = 1;
    send_line(10, 2, 5, 0, 0, 0);
    line_check("stall");
    for (int i = 0; i < 5; i++) begin
      send_line(10, 2, 5, 0, 0, 0);
      line_check("wrap_slot");
    end
    send_line(4, 2, 5, 0, 0, 0);
    line_check("short_part");
    send_line(10, 2, 5, 0, 0, 0);
    line_check("short_next");
    sr_clear = 1;
    @(posedge clk);
    #1;
    sr_clear = 0;
    m_short = 0;
    @(negedge clk);
    check("short_clear", sr_short_line, m_short);
    @(posedge clk);
    #1;
    send_line(4, 2, 5, 0, 0, 0);
    send_line(10, 2, 5, 0, 1, 0);
    line_check("set_wins");
    send_line(12, 0, 4, 1, 0, 0);
    line_check("frame");
    send_line(512, 500, 20, 0, 0, 0);
    line_check("col_wrap");
    send_line(8, 0, 0, 0, 0, 0);
    line_check("len_zero");
    send_line(20, 0, 1000, 0, 0, 0);
    line_check("len_clamp");
    send_line(6, 1, 3, 0, 0, 0);
    line_check("after_clamp");
    for (int i = 0; i < 40; i++) begin
      int st, ln, np;
      st = $urandom_range(0, 30);
      ln = ($urandom_range(0, 7) == 0) ? 600 : $urandom_range(0, 30);
      np = $urandom_range(2, 50);
      send_line(np, st, ln, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 0);
      line_check("rand");
    end
    ack_mode = 2;
    gaps = 0;
    @(posedge clk);
    #1;
    cfg_h_start = 0;
    cfg_h_len = 3;
    src_valid = 1;
    src_pixel = 7;
    src_hsync = 1;
    src_vsync = 0;
    @(posedge clk);
    #1;
    src_hsync = 0;
    src_pixel = 8;
    @(negedge clk);
    check("pre_rst_write", lb_write, 1);
    @(posedge clk);
    #1;
    rst = 0;
    src_valid = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("mid_reset_out");
    exp_q.delete();
    m_slot = 0;
    m_last = 0;
    m_frame = 0;
    m_short = 0;
    m_busy = 0;
    ack_mode = 0;
    @(posedge clk);
    #1;
    rst = 1;
    send_line(10, 2, 5, 0, 0, 0);
    line_check("post_reset");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
